// File: rtl/mem_arb_pkg.sv
// Shared types for the data-port arbiter: access states,
// grant-select encoding and default timing constants.
package mem_arb_pkg;

  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_ACC = 2'd1,
    DMA_ACC = 2'd2
  } arb_state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_CPU  = 2'd1,
    GNT_DMA  = 2'd2
  } gnt_e;

  function automatic arb_state_e gnt_state(gnt_e g);
    arb_state_e s;
    s = IDLE;
    case (g)
      GNT_CPU: s = CPU_ACC;
      GNT_DMA: s = DMA_ACC;
      default: s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating DMA starvation counter.
// Ports: clock, reset, inc, clr (clr wins), sat, count.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX = DEF_STARVE_MAX
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inc,
  input  logic                       clr,
  output logic                       sat,
  output logic [$clog2(MAX+1)-1:0]   count
);

  localparam int W = $clog2(MAX + 1);

  assign sat = (count == W'(MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !sat) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// CPU/DMA arbiter and sequencer for the single data-memory port.
// Ports: clock/reset, cpu_* (MEM stage), dma_*, mem_* (bus).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_LAT - 1);

  arb_state_e        state;
  logic [CW-1:0]     cnt;
  logic              we_q;
  logic              dma_seen;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [SW-1:0]     starve;
  logic              starved;
  logic              in_cpu;
  logic              in_dma;
  logic              fin;
  logic              cpu_fin;
  logic              dma_fin;
  logic              arb_pt;
  logic              cpu_ok;
  logic              dma_ok;
  logic              inc;
  logic              clr;
  gnt_e              gnt;

  assign in_cpu  = (state == CPU_ACC);
  assign in_dma  = (state == DMA_ACC);
  assign fin     = (in_cpu | in_dma) & (cnt == LAST);
  assign cpu_fin = in_cpu & fin;
  assign dma_fin = in_dma & fin;
  assign arb_pt  = (state == IDLE) | fin;

  // The requester finishing this cycle may not re-win the port.
  assign cpu_ok = cpu_req & ~in_cpu;
  assign dma_ok = dma_req & ~in_dma;

  always_comb begin
    gnt = GNT_NONE;
    if (arb_pt) begin
      unique case (1'b1)
        dma_ok & starved:                gnt = GNT_DMA;
        cpu_ok & ~(dma_ok & starved):    gnt = GNT_CPU;
        dma_ok & ~starved & ~cpu_ok:     gnt = GNT_DMA;
        default:                         gnt = GNT_NONE;
      endcase
    end
  end

  // DMA counts as waiting if it asked at any point of the CPU access.
  assign inc = cpu_fin & (dma_seen | dma_req);
  assign clr = (gnt == GNT_DMA);

  mem_arb_starve_cnt #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clock (clock),
    .reset (reset),
    .inc   (inc),
    .clr   (clr),
    .sat   (starved),
    .count (starve)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      we_q     <= 1'b0;
      dma_seen <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else if (arb_pt) begin
      state    <= gnt_state(gnt);
      cnt      <= '0;
      dma_seen <= 1'b0;
      case (gnt)
        GNT_CPU: begin
          we_q    <= cpu_we;
          addr_q  <= cpu_addr;
          wdata_q <= cpu_wdata;
        end
        GNT_DMA: begin
          we_q    <= dma_we;
          addr_q  <= dma_addr;
          wdata_q <= dma_wdata;
        end
        default: begin
          we_q    <= 1'b0;
          addr_q  <= '0;
          wdata_q <= '0;
        end
      endcase
    end else begin
      cnt      <= cnt + CW'(1);
      dma_seen <= dma_seen | (in_cpu & dma_req);
    end
  end

  assign mem_en    = in_cpu | in_dma;
  assign mem_we    = we_q & fin;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rdata = cpu_fin ? mem_rdata : '0;
  assign dma_rdata = dma_fin ? mem_rdata : '0;
  assign dma_ack   = dma_fin;
  assign cpu_stall = cpu_req & ~cpu_fin;

  logic unused_ok;
  assign unused_ok = ^starve;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (MEM_LAT=2, STARVE_MAX=2)
// plus a MEM_LAT=1 instance sharing the same inputs.
module tb_mem_port_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        cpu_req, cpu_we, dma_req, dma_we;
  logic [31:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata, mem_rdata;
  logic [31:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata;
  logic        cpu_stall, dma_ack, mem_en, mem_we;
  logic [31:0] l1_crd, l1_drd, l1_addr, l1_wdata;
  logic        l1_stall, l1_ack, l1_en, l1_we;

  int n_chk = 0;
  int n_fail = 0;

  mem_port_arbiter #(
    .MEM_LAT(2), .STARVE_MAX(2)
  ) dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(
    .MEM_LAT(1), .STARVE_MAX(2)
  ) dut_l1 (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(l1_crd), .cpu_stall(l1_stall),
    .dma_req(dma_req), .dma_we(dma_we),
    .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(l1_drd), .dma_ack(l1_ack),
    .mem_en(l1_en), .mem_we(l1_we),
    .mem_addr(l1_addr), .mem_wdata(l1_wdata),
    .mem_rdata(mem_rdata)
  );

  typedef struct {
    string       nm;
    logic        cr, cw;
    logic [31:0] ca, cd;
    logic        dr, dw;
    logic [31:0] da, dd, mr;
    logic        st, en, we, ak;
    logic [31:0] crd, drd, ma, md;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string nm,
                     input logic [159:0] act,
                     input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input string nm,
                     input logic cr, cw,
                     input logic [31:0] ca, cd,
                     input logic dr, dw,
                     input logic [31:0] da, dd, mr,
                     input logic st, en, we, ak,
                     input logic [31:0] crd, drd, ma, md);
    vec_t v;
    v.nm = nm; v.cr = cr; v.cw = cw; v.ca = ca; v.cd = cd;
    v.dr = dr; v.dw = dw; v.da = da; v.dd = dd; v.mr = mr;
    v.st = st; v.en = en; v.we = we; v.ak = ak;
    v.crd = crd; v.drd = drd; v.ma = ma; v.md = md;
    vq.push_back(v);
  endtask

  // One cycle: drive on negedge, check the control outputs 1 ns later.
  task automatic cyc(input string nm,
                     input logic cr, dr, rst,
                     input logic e_en, e_st, e_we, e_ak,
                     input logic [31:0] e_addr);
    @(negedge clock);
    reset = rst;
    cpu_req = cr;
    dma_req = dr;
    #1;
    chk(nm, {mem_en, cpu_stall, mem_we, dma_ack, mem_addr},
            {e_en, e_st, e_we, e_ak, e_addr});
  endtask

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dma_req = 0; dma_we = 0; dma_addr = 0; dma_wdata = 0;
    mem_rdata = 0;

    // name, cpu(req,we,addr,wdata), dma(req,we,addr,wdata), mem_rdata,
    // exp stall,en,we,ack, cpu_rdata,dma_rdata,mem_addr,mem_wdata
    add("idle",    0,0,0,0,       0,0,0,0, 0,
        0,0,0,0, 0,0,0,0);
    add("ld_req",  1,0,'h10,0,    0,0,0,0, 'hDEADBEEF,
        1,0,0,0, 0,0,0,0);
    add("ld_c0",   1,0,'h10,0,    0,0,0,0, 'hDEADBEEF,
        1,1,0,0, 0,0,'h10,0);
    add("ld_fin",  1,0,'h10,0,    0,0,0,0, 'hDEADBEEF,
        0,1,0,0, 'hDEADBEEF,0,'h10,0);
    add("idle2",   0,0,0,0,       0,0,0,0, 0,
        0,0,0,0, 0,0,0,0);
    add("st_req",  1,1,'h20,'h55, 0,0,0,0, 0,
        1,0,0,0, 0,0,0,0);
    add("st_c0",   1,1,'h20,'h55, 0,0,0,0, 0,
        1,1,0,0, 0,0,'h20,'h55);
    add("st_fin",  1,1,'h20,'h55, 0,0,0,0, 0,
        0,1,1,0, 0,0,'h20,'h55);
    add("idle3",   0,0,0,0,       0,0,0,0, 0,
        0,0,0,0, 0,0,0,0);
    add("both_req",1,0,'h30,0,    1,0,'h40,0, 0,
        1,0,0,0, 0,0,0,0);
    add("both_c0", 1,0,'h30,0,    1,0,'h40,0, 0,
        1,1,0,0, 0,0,'h30,0);
    add("both_cf", 1,0,'h30,0,    1,0,'h40,0, 'h1111,
        0,1,0,0, 'h1111,0,'h30,0);
    add("dma_c0",  0,0,0,0,       1,0,'h40,0, 0,
        0,1,0,0, 0,0,'h40,0);
    add("dma_fin", 0,0,0,0,       1,0,'h40,0, 'h2222,
        0,1,0,1, 0,'h2222,'h40,0);
    add("idle4",   0,0,0,0,       0,0,0,0, 0,
        0,0,0,0, 0,0,0,0);

    // Reset behaviour: outputs quiet, stall tracks cpu_req.
    cyc("rst_idle",  0,0,1, 0,0,0,0, 0);
    cyc("rst_stall", 1,0,1, 0,1,0,0, 0);
    cyc("rst_hold",  1,0,1, 0,1,0,0, 0);
    cyc("rst_rel",   0,0,0, 0,0,0,0, 0);

    foreach (vq[i]) begin
      @(negedge clock);
      cpu_req = vq[i].cr; cpu_we = vq[i].cw;
      cpu_addr = vq[i].ca; cpu_wdata = vq[i].cd;
      dma_req = vq[i].dr; dma_we = vq[i].dw;
      dma_addr = vq[i].da; dma_wdata = vq[i].dd;
      mem_rdata = vq[i].mr;
      #1;
      chk(vq[i].nm,
          {cpu_stall, mem_en, mem_we, dma_ack,
           cpu_rdata, dma_rdata, mem_addr, mem_wdata},
          {vq[i].st, vq[i].en, vq[i].we, vq[i].ak,
           vq[i].crd, vq[i].drd, vq[i].ma, vq[i].md});
    end

    cpu_addr = 32'h100; dma_addr = 32'h200;
    cpu_we = 0; dma_we = 0; cpu_wdata = 0; dma_wdata = 0;
    mem_rdata = 0;

    // DMA pulses during two CPU accesses saturate starve;
    // the next tie in IDLE then goes to DMA.
    cyc("sat_i0",   1,0,0, 0,1,0,0, 0);
    cyc("sat_c0a",  1,1,0, 1,1,0,0, 32'h100);
    cyc("sat_fa",   1,0,0, 1,0,0,0, 32'h100);
    cyc("sat_i1",   1,0,0, 0,1,0,0, 0);
    cyc("sat_c0b",  1,1,0, 1,1,0,0, 32'h100);
    cyc("sat_fb",   1,0,0, 1,0,0,0, 32'h100);
    cyc("sat_i2",   1,1,0, 0,1,0,0, 0);
    cyc("sat_dma0", 1,1,0, 1,1,0,0, 32'h200);
    cyc("sat_dmaf", 1,1,0, 1,1,0,1, 32'h200);
    cyc("sat_cpu",  1,0,0, 1,1,0,0, 32'h100);
    cyc("sat_cpuf", 1,0,0, 1,0,0,0, 32'h100);
    cyc("sat_end",  0,0,0, 0,0,0,0, 0);

    // CPU continuous, DMA arrives in the gap: CPU, CPU, DMA,
    // then starve is back at 0 (one more pulse is not enough).
    cyc("p_i0",  1,0,0, 0,1,0,0, 0);
    cyc("p_c0",  1,0,0, 1,1,0,0, 32'h100);
    cyc("p_cf",  1,0,0, 1,0,0,0, 32'h100);
    cyc("p_i1",  1,1,0, 0,1,0,0, 0);
    cyc("p_c1",  1,1,0, 1,1,0,0, 32'h100);
    cyc("p_c1f", 1,1,0, 1,0,0,0, 32'h100);
    cyc("p_d0",  1,1,0, 1,1,0,0, 32'h200);
    cyc("p_df",  1,1,0, 1,1,0,1, 32'h200);
    cyc("p_c2",  1,1,0, 1,1,0,0, 32'h100);
    cyc("p_c2f", 1,0,0, 1,0,0,0, 32'h100);
    cyc("p_i2",  1,1,0, 0,1,0,0, 0);
    cyc("p_c3",  1,0,0, 1,1,0,0, 32'h100);
    cyc("p_c3f", 1,0,0, 1,0,0,0, 32'h100);
    cyc("p_end", 0,0,0, 0,0,0,0, 0);

    // Reset during a DMA write.
    dma_addr = 32'h300; dma_wdata = 32'hAA; dma_we = 1;
    cyc("r_i",      0,1,0, 0,0,0,0, 0);
    cyc("r_d0",     0,1,1, 1,0,0,0, 32'h300);
    cyc("r_after",  0,0,0, 0,0,0,0, 0);
    cyc("r_idle",   0,0,0, 0,0,0,0, 0);
    cyc("rf_i",     0,1,0, 0,0,0,0, 0);
    cyc("rf_d0",    0,1,0, 1,0,0,0, 32'h300);
    cyc("rf_fin",   0,1,1, 1,0,1,1, 32'h300);
    cyc("rf_after", 0,0,0, 0,0,0,0, 0);
    dma_we = 0;

    // Single-cycle memory instance.
    @(negedge clock);
    cpu_req = 1; cpu_addr = 32'h10; mem_rdata = 32'hCAFE;
    #1;
    chk("l1_req", {l1_en, l1_stall}, {1'b0, 1'b1});
    @(negedge clock); #1;
    chk("l1_fin", {l1_en, l1_stall, l1_crd, l1_addr},
                  {1'b1, 1'b0, 32'hCAFE, 32'h10});
    @(negedge clock); #1;
    chk("l1_gap", {l1_en, l1_stall, l1_crd},
                  {1'b0, 1'b1, 32'h0});
    @(negedge clock); #1;
    chk("l1_again", {l1_en, l1_stall}, {1'b1, 1'b0});
    @(negedge clock);
    cpu_req = 0;

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
